ifft16_seq: RTL and testbench

IFFT16_SEQ -- requirements
Module: ifft16_seq

---
 rtl/ifft16_seq.sv | 189 ++++++++++++++++++
 tb/tb_ifft16_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft16_seq.sv
// Sequential 16-point inverse DFT: loads 16 complex bins, then computes one real,
// rounded and saturated 8-bit time sample per 16-cycle MAC pass.
module ifft16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] in_re,
    input  logic [27:0] in_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_sample,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCalc,
        StRound,
        StOut
    } state_e;

    state_e state_q, state_d;

    logic        [3:0]  k_q;
    logic        [3:0]  n_q;
    logic signed [47:0] acc_q;
    logic        [7:0]  sample_q;
    logic               valid_q;
    logic               last_q;

    logic signed [27:0] bin_re_q [16];
    logic signed [27:0] bin_im_q [16];

    logic               load_en;
    logic               mac_en;
    logic               round_en;
    logic               out_hs;

    logic        [3:0]  m_idx;
    logic        [3:0]  s_idx;
    logic signed [15:0] c_val;
    logic signed [15:0] s_val;
    logic signed [27:0] re_cur;
    logic signed [27:0] im_cur;
    logic signed [43:0] prod_re;
    logic signed [43:0] prod_im;
    logic signed [47:0] term;
    logic signed [47:0] rnd_sh;
    logic        [7:0]  sat_val;

    // Q1.14 cosine table; the sine is the same table rotated by a quarter turn.
    function automatic logic signed [15:0] cos_rom(input logic [3:0] m);
        case (m)
            4'd0:    return 16'sd16384;
            4'd1:    return 16'sd15137;
            4'd2:    return 16'sd11585;
            4'd3:    return 16'sd6270;
            4'd4:    return 16'sd0;
            4'd5:    return -16'sd6270;
            4'd6:    return -16'sd11585;
            4'd7:    return -16'sd15137;
            4'd8:    return -16'sd16384;
            4'd9:    return -16'sd15137;
            4'd10:   return -16'sd11585;
            4'd11:   return -16'sd6270;
            4'd12:   return 16'sd0;
            4'd13:   return 16'sd6270;
            4'd14:   return 16'sd11585;
            default: return 16'sd15137;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StLoad;
            StLoad:  if (in_valid && k_q == 4'd15) state_d = StCalc;
            StCalc:  if (k_q == 4'd15) state_d = StRound;
            StRound: state_d = StOut;
            StOut: begin
                if (out_ready) state_d = (n_q == 4'd15) ? StIdle : StCalc;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath-control decode
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        mac_en   = 1'b0;
        round_en = 1'b0;
        out_hs   = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            StLoad:  in_ready = 1'b1;
            StCalc:  mac_en = 1'b1;
            StRound: round_en = 1'b1;
            StOut:   out_hs = out_ready;
            default: busy = 1'b0;
        endcase
        load_en = in_ready & in_valid;
    end

    assign m_idx   = n_q * k_q;
    assign s_idx   = m_idx + 4'd12;
    assign c_val   = cos_rom(m_idx);
    assign s_val   = cos_rom(s_idx);
    assign re_cur  = bin_re_q[k_q];
    assign im_cur  = bin_im_q[k_q];
    assign prod_re = re_cur * c_val;
    assign prod_im = im_cur * s_val;
    assign term    = 48'(prod_re) - 48'(prod_im);

    // Round half up at the 2^18 scale (1/16 normalisation times Q1.14), then clamp.
    assign rnd_sh = (acc_q + 48'sd131072) >>> 18;

    always_comb begin
        if (rnd_sh < 48'sd0) begin
            sat_val = 8'd0;
        end else if (rnd_sh > 48'sd255) begin
            sat_val = 8'd255;
        end else begin
            sat_val = rnd_sh[7:0];
        end
    end

    // Bin storage is written only while loading, so it stays frozen for the whole frame.
    always_ff @(posedge clk) begin
        if (!rst && load_en) begin
            bin_re_q[k_q] <= in_re;
            bin_im_q[k_q] <= in_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= 4'd0;
            n_q      <= 4'd0;
            acc_q    <= 48'sd0;
            sample_q <= 8'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            if (load_en) begin
                k_q   <= k_q + 4'd1;
                n_q   <= 4'd0;
                acc_q <= 48'sd0;
            end
            if (mac_en) begin
                acc_q <= acc_q + term;
                k_q   <= k_q + 4'd1;
            end
            if (round_en) begin
                sample_q <= sat_val;
                valid_q  <= 1'b1;
                last_q   <= (n_q == 4'd15);
            end
            if (out_hs) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                n_q     <= n_q + 4'd1;
                k_q     <= 4'd0;
                acc_q   <= 48'sd0;
            end
        end
    end

    assign out_sample = sample_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;

endmodule

// File: tb/tb_ifft16_seq.sv
// Scoreboard bench for ifft16_seq: a real-arithmetic reference model queues expected
// samples per frame, and a monitor checks every output handshake against the queue.
module tb_ifft16_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_re = '0;
    logic [27:0] in_im = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_sample;
    logic        out_last;
    logic        busy;

    ifft16_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    localparam real Pi = 3.14159265358979;

    int         errors = 0;
    int         checks = 0;
    int         pops = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_e;
    bit         rand_rdy = 1'b0;
    bit         stall = 1'b0;
    int         ctab[16];
    int         stab[16];
    int         bre[16];
    int         bim[16];
    int         xs[16];

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (stall) out_ready = 1'b0;
        else if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = 1'b1;
    end

    // Monitor: one pop per output handshake
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected no output", out_sample);
            end else begin
                exp_e = exp_q.pop_front();
                chk("sample", longint'(out_sample), longint'(exp_e[7:0]));
                chk("last", longint'(out_last), longint'(exp_e[8]));
            end
            pops++;
        end
    end

    // Reference: x[n] = round-half-up(sum Re(X[k] * W^(nk)) / 2^18) using Q1.14 twiddles
    task automatic push_expected();
        longint acc;
        longint v;
        int     m;
        for (int n = 0; n < 16; n++) begin
            acc = 0;
            for (int k = 0; k < 16; k++) begin
                m   = (n * k) % 16;
                acc = acc + longint'(bre[k]) * ctab[m] - longint'(bim[k]) * stab[m];
            end
            v = (acc + 131072) >>> 18;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            exp_q.push_back({(n == 15) ? 1'b1 : 1'b0, 8'(v)});
        end
    endtask

    task automatic dft_of_samples();
        real r;
        real i;
        for (int k = 0; k < 16; k++) begin
            r = 0.0;
            i = 0.0;
            for (int n = 0; n < 16; n++) begin
                r = r + xs[n] * $cos(2.0 * Pi * n * k / 16.0);
                i = i - xs[n] * $sin(2.0 * Pi * n * k / 16.0);
            end
            bre[k] = rnd(r);
            bim[k] = rnd(i);
        end
    endtask

    task automatic set_dc(input int x0);
        for (int k = 0; k < 16; k++) begin
            bre[k] = 0;
            bim[k] = 0;
        end
        bre[0] = x0;
    endtask

    task automatic send_bin(input int k);
        bit ok;
        int t;
        ok       = 1'b0;
        t        = 0;
        in_valid = 1'b1;
        in_re    = 28'(bre[k]);
        in_im    = 28'(bim[k]);
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL bin_accept: got in_ready=0 for 100 cycles expected acceptance of bin %0d", k);
        end
    endtask

    task automatic send_frame(input bit hold);
        push_expected();
        for (int k = 0; k < 16; k++) send_bin(k);
        if (hold) begin
            in_re = 28'($urandom);
            in_im = 28'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_frame(input bit check_ready);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
            if (check_ready && busy) chk("in_ready_busy", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d samples pending expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_frame", longint'(busy), 0);
    endtask

    task automatic wait_pops(input int target);
        int t;
        t = 0;
        while (pops < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (pops < target) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout: got %0d outputs expected %0d", pops, target);
        end
    endtask

    task automatic pulse_reset_and_check(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_out_sample"}, longint'(out_sample), 0);
        chk({tag, "_out_last"}, longint'(out_last), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_in_ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected completion within 5 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int t;
        logic [7:0] held;
        int samp32[16] = '{80, 38, 182, 112, 72, 84, 232, 84, 40, 116, 104, 52, 184, 116, 46, 116};

        for (int m = 0; m < 16; m++) begin
            ctab[m] = rnd(16384.0 * $cos(2.0 * Pi * m / 16.0));
            stab[m] = rnd(16384.0 * $sin(2.0 * Pi * m / 16.0));
        end

        repeat (3) @(posedge clk);
        #1;
        pulse_reset_and_check("reset");

        // DC frame with latency check
        set_dc(1600);
        send_frame(1'b0);
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (i == 16) chk("latency_edge16_valid", longint'(out_valid), 0);
            if (i == 17) chk("latency_edge17_valid", longint'(out_valid), 1);
        end
        wait_frame(1'b1);

        // Nyquist alternation and low saturation
        set_dc(4080);
        bre[8] = -4080;
        send_frame(1'b0);
        wait_frame(1'b1);
        set_dc(-1600);
        send_frame(1'b0);
        wait_frame(1'b1);

        // Known waveform, in_valid held during compute, stall at sample 3
        xs = samp32;
        dft_of_samples();
        p0 = pops;
        send_frame(1'b1);
        wait_pops(p0 + 3);
        stall = 1'b1;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("stall_reached_valid", longint'(out_valid), 1);
        held = out_sample;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", longint'(out_valid), 1);
            chk("stall_sample", longint'(out_sample), longint'(held));
        end
        chk("stall_no_pop", pops, p0 + 3);
        stall = 1'b0;
        wait_frame(1'b1);

        // Reset in CALC of n=5, then a fresh DC frame
        set_dc(1600);
        p0 = pops;
        send_frame(1'b0);
        wait_pops(p0 + 5);
        repeat (6) @(posedge clk);
        #1;
        pulse_reset_and_check("calc_reset");
        send_frame(1'b0);
        wait_frame(1'b1);

        // Reset mid-load must restart the bin index
        for (int n = 0; n < 16; n++) xs[n] = $urandom_range(0, 255);
        dft_of_samples();
        for (int k = 0; k < 7; k++) send_bin(k);
        in_valid = 1'b0;
        pulse_reset_and_check("load_reset");
        send_frame(1'b0);
        wait_frame(1'b1);

        // Random waveforms and random wide bins under random backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 16; n++) xs[n] = $urandom_range(0, 255);
            dft_of_samples();
            send_frame(f[0]);
            wait_frame(1'b1);
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) begin
                bre[k] = int'($urandom_range(0, 268435455)) - 134217728;
                bim[k] = int'($urandom_range(0, 268435455)) - 134217728;
            end
            send_frame(1'b0);
            wait_frame(1'b1);
        end
        rand_rdy = 1'b0;

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
